// File: rtl/wildcard_match_filter.sv
// Streaming classifier: tags each word with value/care-mask pattern hits.
// Optional saturating hit counter enabled by defining WILDCARD_HIT_COUNT_EN.
module wildcard_match_filter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_PAT = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [DATA_W-1:0]  cfg_value,
    input  logic [DATA_W-1:0]  cfg_care,
    input  logic               cfg_enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_hit,
    output logic [NUM_PAT-1:0] out_hit_vec,
    output logic [IDX_W-1:0]   out_hit_idx
`ifdef WILDCARD_HIT_COUNT_EN
    ,
    input  logic               hit_count_clr,
    output logic [CNT_W-1:0]   hit_count
`endif
);

    logic [DATA_W-1:0]  r_value [NUM_PAT];
    logic [DATA_W-1:0]  r_care  [NUM_PAT];
    logic [NUM_PAT-1:0] r_enable;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_hit;
    logic [NUM_PAT-1:0] r_out_hit_vec;
    logic [IDX_W-1:0]   r_out_hit_idx;

    logic               w_in_fire;
    logic               w_out_fire;
    logic [NUM_PAT-1:0] w_hit_vec;
    logic [IDX_W-1:0]   w_hit_idx;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Pattern table; out-of-range indices are silently dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= '0;
            for (int i = 0; i < int'(NUM_PAT); i++) begin
                r_value[i] <= '0;
                r_care[i]  <= '0;
            end
        end else if (cfg_we && (32'(cfg_idx) < 32'(NUM_PAT))) begin
            r_value[cfg_idx]  <= cfg_value;
            r_care[cfg_idx]   <= cfg_care;
            r_enable[cfg_idx] <= cfg_enable;
        end
    end

    // Masked compare against the table as it stood before this edge
    always_comb begin
        w_hit_vec = '0;
        for (int i = 0; i < int'(NUM_PAT); i++) begin
            w_hit_vec[i] = r_enable[i] && (((in_data ^ r_value[i]) & r_care[i]) == '0);
        end
    end

    // Lowest set bit wins; scan downward so the last assignment is the lowest
    always_comb begin
        w_hit_idx = '0;
        for (int i = int'(NUM_PAT) - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_hit     <= 1'b0;
            r_out_hit_vec <= '0;
            r_out_hit_idx <= '0;
        end else if (w_in_fire) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= in_data;
            r_out_hit     <= |w_hit_vec;
            r_out_hit_vec <= w_hit_vec;
            r_out_hit_idx <= w_hit_idx;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_hit     = r_out_hit;
    assign out_hit_vec = r_out_hit_vec;
    assign out_hit_idx = r_out_hit_idx;

`ifdef WILDCARD_HIT_COUNT_EN
    logic [CNT_W-1:0] r_hit_count;

    // Clear has priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count <= '0;
        end else if (hit_count_clr) begin
            r_hit_count <= '0;
        end else if (w_out_fire && r_out_hit && (r_hit_count != '1)) begin
            r_hit_count <= r_hit_count + CNT_W'(1);
        end
    end

    assign hit_count = r_hit_count;
`else
    logic w_unused;
    assign w_unused = w_out_fire;
`endif

endmodule

// File: tb/tb_wildcard_match_filter.sv
// Directed self-checking bench for wildcard_match_filter.
// Counter scenario is compiled in only with WILDCARD_HIT_COUNT_EN.
module tb_wildcard_match_filter;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_value;
    logic [7:0] cfg_care;
    logic       cfg_enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_hit;
    logic [3:0] out_hit_vec;
    logic [1:0] out_hit_idx;
`ifdef WILDCARD_HIT_COUNT_EN
    logic       hit_count_clr;
    logic [1:0] hit_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    wildcard_match_filter #(
        .DATA_W (8),
        .NUM_PAT(4),
        .IDX_W  (2),
`ifdef WILDCARD_HIT_COUNT_EN
        .CNT_W  (2)
`else
        .CNT_W  (16)
`endif
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_value   (cfg_value),
        .cfg_care    (cfg_care),
        .cfg_enable  (cfg_enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_hit     (out_hit),
        .out_hit_vec (out_hit_vec),
        .out_hit_idx (out_hit_idx)
`ifdef WILDCARD_HIT_COUNT_EN
        ,
        .hit_count_clr(hit_count_clr),
        .hit_count    (hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: drive at negedge, effect at next posedge
    task automatic cfg_write(input logic [1:0] idx, input logic [7:0] val,
                             input logic [7:0] care, input logic en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_value = val; cfg_care = care; cfg_enable = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Leaves the result visible at the negedge following the transfer
    task automatic send_word(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %0h want 00", out_data); end
        n_cmp++; if ({out_hit, out_hit_vec, out_hit_idx} !== 7'd0) begin n_fail++; $display("FAIL rst_hit got %0h/%0h/%0h want 0/0/0", out_hit, out_hit_vec, out_hit_idx); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0h want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_match;
        cfg_write(2'd0, 8'hA0, 8'hF0, 1'b1);
        send_word(8'hA0);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %0h want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA0) begin n_fail++; $display("FAIL t1_data got %0h want a0", out_data); end
        n_cmp++; if ({out_hit, out_hit_vec, out_hit_idx} !== {1'b1, 4'b0001, 2'd0}) begin n_fail++; $display("FAIL t1_hit_a0 got %0h/%0h/%0h want 1/1/0", out_hit, out_hit_vec, out_hit_idx); end
        send_word(8'hB0);
        n_cmp++; if ({out_hit, out_hit_vec, out_hit_idx} !== 7'd0) begin n_fail++; $display("FAIL t1_miss_b0 got %0h/%0h/%0h want 0/0/0", out_hit, out_hit_vec, out_hit_idx); end
    endtask

    task automatic test_dont_care;
        cfg_write(2'd1, 8'h00, 8'h00, 1'b1);
        send_word(8'hA5);
        n_cmp++; if ({out_hit, out_hit_vec, out_hit_idx} !== {1'b1, 4'b0011, 2'd0}) begin n_fail++; $display("FAIL t2_a5 got %0h/%0h/%0h want 1/3/0", out_hit, out_hit_vec, out_hit_idx); end
        send_word(8'h00);
        n_cmp++; if ({out_hit, out_hit_vec, out_hit_idx} !== {1'b1, 4'b0010, 2'd1}) begin n_fail++; $display("FAIL t2_00 got %0h/%0h/%0h want 1/2/1", out_hit, out_hit_vec, out_hit_idx); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t3_in_ready[%0d] got %0h want 0", c, in_ready); end
            n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL t3_hold[%0d] got %0h/%0h want 1/11", c, out_valid, out_data); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL t3_next got %0h/%0h want 1/22", out_valid, out_data); end
        n_cmp++; if (out_hit_vec !== 4'b0010) begin n_fail++; $display("FAIL t3_vec got %0h want 2", out_hit_vec); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t3_drain got %0h want 0", out_valid); end
    endtask

    task automatic test_write_same_cycle;
        cfg_write(2'd1, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_value = 8'h55; cfg_care = 8'hFF; cfg_enable = 1'b1;
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_hit, out_hit_vec} !== {1'b1, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL t4_old got %0h/%0h/%0h want 1/0/0", out_valid, out_hit, out_hit_vec); end
        send_word(8'h55);
        n_cmp++; if ({out_hit, out_hit_vec, out_hit_idx} !== {1'b1, 4'b0001, 2'd0}) begin n_fail++; $display("FAIL t4_new got %0h/%0h/%0h want 1/1/0", out_hit, out_hit_vec, out_hit_idx); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        logic       hits  [3];
        words[0] = 8'h55; words[1] = 8'h54; words[2] = 8'h55;
        hits[0]  = 1'b1;  hits[1]  = 1'b0;  hits[2]  = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = words[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({in_ready, out_valid, out_data, out_hit} !== {1'b1, 1'b1, words[k], hits[k]})
                begin n_fail++; $display("FAIL b2b[%0d] got rdy=%0h v=%0h d=%0h h=%0h want 1/1/%0h/%0h", k, in_ready, out_valid, out_data, out_hit, words[k], hits[k]); end
            if (k < 2) in_data = words[k+1];
            else       in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_hit} !== 2'b11) begin n_fail++; $display("FAIL t5_pre got %0h/%0h want 1/1", out_valid, out_hit); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_data, out_hit, out_hit_vec, out_hit_idx} !== 16'd0) begin n_fail++; $display("FAIL t5_async got v=%0h d=%0h h=%0h vec=%0h idx=%0h want all 0", out_valid, out_data, out_hit, out_hit_vec, out_hit_idx); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t5_discard got %0h want 0", out_valid); end
        send_word(8'hA0);
        n_cmp++; if ({out_valid, out_hit, out_hit_vec} !== {1'b1, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL t5_cleared got %0h/%0h/%0h want 1/0/0", out_valid, out_hit, out_hit_vec); end
    endtask

`ifdef WILDCARD_HIT_COUNT_EN
    task automatic test_hit_count;
        @(negedge clk);
        n_cmp++; if (hit_count !== 2'd0) begin n_fail++; $display("FAIL t6_start got %0h want 0", hit_count); end
        cfg_write(2'd0, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) send_word(8'(k));
        @(negedge clk);
        n_cmp++; if (hit_count !== 2'd3) begin n_fail++; $display("FAIL t6_sat got %0h want 3", hit_count); end
        send_word(8'h77);
        hit_count_clr = 1'b1;
        @(negedge clk);
        hit_count_clr = 1'b0;
        n_cmp++; if (hit_count !== 2'd0) begin n_fail++; $display("FAIL t6_clr got %0h want 0", hit_count); end
    endtask
`endif

    initial begin
        cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_care = '0; cfg_enable = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef WILDCARD_HIT_COUNT_EN
        hit_count_clr = 1'b0;
`endif
        test_reset();
        test_basic_match();
        test_dont_care();
        test_backpressure();
        test_write_same_cycle();
        test_back_to_back();
        test_reset_midflight();
`ifdef WILDCARD_HIT_COUNT_EN
        test_hit_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
